// File: rtl/prog_loader_pkg.sv
// Shared types for the program loader: FSM state encoding and processor status codes.
// The status codes are also used by the processor top.
package prog_loader_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_RUN,
      ST_HALTED,
      ST_ERROR
   } state_t;

   localparam logic [1:0] STAT_AOK = 2'd0;
   localparam logic [1:0] STAT_HLT = 2'd1;
   localparam logic [1:0] STAT_INS = 2'd2;
   localparam logic [1:0] STAT_ERR = 2'd3;

   function automatic logic is_stopped(input logic [1:0] st);
      return st != STAT_AOK;
   endfunction

endpackage

// File: rtl/prog_loader.sv
// Streams a program into instruction memory, then runs the processor until it stops.
// Optional: define PROG_LOADER_CHECKSUM_EN to treat the in_last byte as a modulo-256 checksum.
module prog_loader
   import prog_loader_pkg::*;
#(
   parameter int unsigned MEM_BYTES = 1024,
   parameter int unsigned ADDR_W    = 10
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [7:0]        in_data,
   input  logic              in_last,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [7:0]        imem_wdata,
   input  logic [1:0]        cpu_status,
   output logic              cpu_run,
   output logic              load_err,
   output logic [1:0]        final_status,
   output logic [ADDR_W:0]   byte_count
);

   localparam logic [ADDR_W:0] FULL = (ADDR_W+1)'(MEM_BYTES);
   localparam logic [ADDR_W:0] ONE  = (ADDR_W+1)'(1);

   state_t state, nxt;
   logic   accept, is_data, full, ovf, wr, restart;

   assign accept  = in_valid && in_ready;
   assign full    = (byte_count == FULL);
   assign ovf     = accept && is_data && full;
   assign wr      = accept && is_data && !full;
   assign restart = start && (state == ST_IDLE || state == ST_HALTED || state == ST_ERROR);

`ifdef PROG_LOADER_CHECKSUM_EN
   logic [7:0] csum;
   logic       csum_ok;

   assign is_data = !in_last;
   assign csum_ok = (csum == in_data);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       csum <= '0;
      else if (restart) csum <= '0;
      else if (wr)      csum <= csum + in_data;
   end
`else
   assign is_data = 1'b1;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= nxt;
   end

   always_comb begin
      nxt = state;
      case (state)
         ST_IDLE, ST_HALTED, ST_ERROR: if (start) nxt = ST_LOAD;
         ST_LOAD: begin
            if (ovf) nxt = ST_ERROR;
            else if (accept && in_last) begin
`ifdef PROG_LOADER_CHECKSUM_EN
               nxt = csum_ok ? ST_RUN : ST_ERROR;
`else
               nxt = ST_RUN;
`endif
            end
         end
         ST_RUN:  if (is_stopped(cpu_status)) nxt = ST_HALTED;
         default: nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      in_ready = (state == ST_LOAD);
   end

   // cpu_run lags the RUN entry by one cycle so the final write lands before the core starts
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         imem_we      <= 1'b0;
         imem_addr    <= '0;
         imem_wdata   <= '0;
         cpu_run      <= 1'b0;
         load_err     <= 1'b0;
         final_status <= STAT_AOK;
         byte_count   <= '0;
      end else begin
         imem_we <= wr;
         cpu_run <= (state == ST_RUN) && (nxt == ST_RUN);
         if (wr) begin
            imem_addr  <= byte_count[ADDR_W-1:0];
            imem_wdata <= in_data;
            byte_count <= byte_count + ONE;
         end
         if (restart) begin
            byte_count   <= '0;
            load_err     <= 1'b0;
            final_status <= STAT_AOK;
         end
         if (state == ST_LOAD && nxt == ST_ERROR) load_err <= 1'b1;
         if (state == ST_RUN && nxt == ST_HALTED) final_status <= cpu_status;
      end
   end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: default-size instance plus a 16-byte instance for overflow.
// Honours PROG_LOADER_CHECKSUM_EN to select the checksum scenarios.
module tb_prog_loader;
   import prog_loader_pkg::*;

   logic clk = 1'b0, rst_n = 1'b0;
   logic start_a = 1'b0, start_b = 1'b0;
   logic in_valid = 1'b0, in_last = 1'b0;
   logic [7:0] in_data = '0;
   logic [1:0] status_a = STAT_AOK, status_b = STAT_AOK;

   logic rdy_a, we_a, run_a, err_a;
   logic [9:0] addr_a;
   logic [7:0] wd_a;
   logic [1:0] fs_a;
   logic [10:0] bc_a;

   logic rdy_b, we_b, run_b, err_b;
   logic [3:0] addr_b;
   logic [7:0] wd_b;
   logic [1:0] fs_b;
   logic [4:0] bc_b;

   int unsigned n_cmp = 0, n_bad = 0, gapbad = 0;
   logic use_b = 1'b0;
   logic [7:0] strm[$];
   int unsigned qa_addr[$], qb_addr[$];
   logic [7:0] qa_data[$], qb_data[$];

   always #5 clk = ~clk;

   prog_loader #(.MEM_BYTES(1024), .ADDR_W(10)) dut_a (
      .clk(clk), .rst_n(rst_n), .start(start_a), .in_valid(in_valid), .in_ready(rdy_a),
      .in_data(in_data), .in_last(in_last), .imem_we(we_a), .imem_addr(addr_a),
      .imem_wdata(wd_a), .cpu_status(status_a), .cpu_run(run_a), .load_err(err_a),
      .final_status(fs_a), .byte_count(bc_a));

   prog_loader #(.MEM_BYTES(16), .ADDR_W(4)) dut_b (
      .clk(clk), .rst_n(rst_n), .start(start_b), .in_valid(in_valid), .in_ready(rdy_b),
      .in_data(in_data), .in_last(in_last), .imem_we(we_b), .imem_addr(addr_b),
      .imem_wdata(wd_b), .cpu_status(status_b), .cpu_run(run_b), .load_err(err_b),
      .final_status(fs_b), .byte_count(bc_b));

   always @(negedge clk) begin
      if (we_a) begin qa_addr.push_back(int'(addr_a)); qa_data.push_back(wd_a); end
      if (we_b) begin qb_addr.push_back(int'(addr_b)); qb_data.push_back(wd_b); end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic clear_q;
      qa_addr.delete(); qa_data.delete(); qb_addr.delete(); qb_data.delete();
   endtask

   task automatic pulse_a;
      start_a = 1'b1; @(negedge clk); start_a = 1'b0;
   endtask

   task automatic pulse_b;
      start_b = 1'b1; @(negedge clk); start_b = 1'b0;
   endtask

   // Drives strm from the current negedge; with gap set, in_valid is high every other cycle.
   task automatic send(input bit gap, input bit chkwe, input int unsigned nmax);
      int unsigned i = 0, cyc = 0;
      logic acc;
      while (i < nmax && cyc < 400) begin
         in_valid = gap ? (cyc % 2 == 0) : 1'b1;
         in_data  = strm[i];
         in_last  = (i == strm.size() - 1);
         acc      = in_valid && (use_b ? rdy_b : rdy_a);
         @(negedge clk);
         if (chkwe && ((use_b ? we_b : we_a) !== acc)) gapbad++;
         if (acc) i++;
         cyc++;
      end
      in_valid = 1'b0; in_last = 1'b0;
      if (i < nmax) chk("send_timeout", i, nmax);
   endtask

   task automatic chk_writes_a(input string tag);
      chk({tag, "_nwr"}, qa_addr.size(), strm.size());
      for (int unsigned i = 0; i < qa_addr.size() && i < strm.size(); i++) begin
         chk($sformatf("%s_addr[%0d]", tag, i), qa_addr[i], i);
         chk($sformatf("%s_data[%0d]", tag, i), qa_data[i], strm[i]);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (2) @(negedge clk);
      chk("rst_ready", rdy_a, 0);
      chk("rst_we", we_a, 0);
      chk("rst_addr", addr_a, 0);
      chk("rst_wdata", wd_a, 0);
      chk("rst_run", run_a, 0);
      chk("rst_err", err_a, 0);
      chk("rst_fstat", fs_a, 0);
      chk("rst_bcount", bc_a, 0);
      rst_n = 1'b1;
      @(negedge clk);

`ifndef PROG_LOADER_CHECKSUM_EN
      // basic 5-byte load
      pulse_a;
      chk("load_ready", rdy_a, 1);
      chk("load_bc0", bc_a, 0);
      clear_q;
      strm.delete();
      strm.push_back(8'h30); strm.push_back(8'hF2); strm.push_back(8'h0A);
      strm.push_back(8'h00); strm.push_back(8'h00);
      gapbad = 0;
      send(1'b0, 1'b1, 5);
      chk("last_ready_drop", rdy_a, 0);
      chk("run_1cyc", run_a, 0);
      @(negedge clk);
      chk("run_2cyc", run_a, 1);
      chk("bcount5", bc_a, 5);
      chk_writes_a("basic");
      chk("basic_we_accept", gapbad, 0);

      // start ignored while running
      pulse_a;
      chk("run_start_ready", rdy_a, 0);
      chk("run_start_bc", bc_a, 5);
      chk("run_start_run", run_a, 1);

      // halt capture and restart
      status_a = STAT_HLT;
      @(negedge clk);
      chk("halt_fstat", fs_a, 1);
      chk("halt_run", run_a, 0);
      status_a = STAT_AOK;
      @(negedge clk);
      chk("halted_hold_fs", fs_a, 1);
      chk("halted_hold_run", run_a, 0);
      pulse_a;
      chk("restart_ready", rdy_a, 1);
      chk("restart_fstat", fs_a, 0);
      chk("restart_bc", bc_a, 0);

      // in_valid toggling every other cycle
      clear_q;
      strm.delete();
      for (int unsigned i = 0; i < 6; i++) strm.push_back(8'hA0 + 8'(i));
      gapbad = 0;
      send(1'b1, 1'b1, 6);
      @(negedge clk);
      chk_writes_a("gap");
      chk("gap_we_accept", gapbad, 0);
      chk("gap_run", run_a, 1);
`endif

      // reset in the middle of a load
      rst_n = 1'b0; @(negedge clk); rst_n = 1'b1; @(negedge clk);
      pulse_a;
      clear_q;
      strm.delete();
      for (int unsigned i = 0; i < 10; i++) strm.push_back(8'h10 + 8'(i));
      send(1'b0, 1'b0, 3);
      chk("pre_rst_we", we_a, 1);
      chk("pre_rst_addr", addr_a, 2);
      chk("pre_rst_bc", bc_a, 3);
      #1 rst_n = 1'b0;
      #1;
      chk("arst_we", we_a, 0);
      chk("arst_addr", addr_a, 0);
      chk("arst_wdata", wd_a, 0);
      chk("arst_bc", bc_a, 0);
      chk("arst_ready", rdy_a, 0);
      chk("arst_run", run_a, 0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int unsigned i = 3; i < 10; i++) begin
         in_valid = 1'b1; in_data = strm[i]; in_last = (i == 9);
         @(negedge clk);
      end
      in_valid = 1'b0; in_last = 1'b0;
      chk("arst_ignored_nwr", qa_addr.size(), 3);
      chk("arst_ignored_bc", bc_a, 0);
      chk("arst_ignored_ready", rdy_a, 0);

`ifndef PROG_LOADER_CHECKSUM_EN
      // overflow on the 16-byte instance
      use_b = 1'b1;
      pulse_b;
      clear_q;
      strm.delete();
      for (int unsigned i = 0; i < 17; i++) strm.push_back(8'h40 + 8'(i));
      send(1'b0, 1'b0, 17);
      repeat (2) @(negedge clk);
      chk("ovf_nwr", qb_addr.size(), 16);
      for (int unsigned i = 0; i < qb_addr.size() && i < 16; i++) begin
         chk($sformatf("ovf_addr[%0d]", i), qb_addr[i], i);
         chk($sformatf("ovf_data[%0d]", i), qb_data[i], strm[i]);
      end
      chk("ovf_err", err_b, 1);
      chk("ovf_run", run_b, 0);
      chk("ovf_bc", bc_b, 16);
      chk("ovf_ready", rdy_b, 0);
      pulse_b;
      chk("err_restart_ready", rdy_b, 1);
      chk("err_restart_err", err_b, 0);
      chk("err_restart_bc", bc_b, 0);
      use_b = 1'b0;
`else
      // checksum match then mismatch
      pulse_a;
      clear_q;
      strm.delete();
      strm.push_back(8'h01); strm.push_back(8'h02); strm.push_back(8'h03); strm.push_back(8'h06);
      send(1'b0, 1'b0, 4);
      chk("cs_run_1cyc", run_a, 0);
      @(negedge clk);
      chk("cs_ok_run", run_a, 1);
      chk("cs_ok_err", err_a, 0);
      chk("cs_ok_bc", bc_a, 3);
      chk("cs_ok_nwr", qa_addr.size(), 3);
      for (int unsigned i = 0; i < qa_addr.size() && i < 3; i++) begin
         chk($sformatf("cs_addr[%0d]", i), qa_addr[i], i);
         chk($sformatf("cs_data[%0d]", i), qa_data[i], strm[i]);
      end
      status_a = STAT_HLT; @(negedge clk); status_a = STAT_AOK;
      pulse_a;
      clear_q;
      strm[3] = 8'h07;
      send(1'b0, 1'b0, 4);
      @(negedge clk);
      chk("cs_bad_err", err_a, 1);
      chk("cs_bad_run", run_a, 0);
      chk("cs_bad_ready", rdy_a, 0);
      chk("cs_bad_nwr", qa_addr.size(), 3);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter MEM_BYTES, default 1024, SHALL set the instruction-memory size in bytes (power of two, at most 4096).
REQ-002 Parameter ADDR_W, default 10, SHALL set the memory address width, equal to log2(MEM_BYTES).
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 start  input  1  SHALL be a one-cycle pulse requesting a new program load.
REQ-006 in_valid  input  1  SHALL mark in_data/in_last as valid.
REQ-007 in_ready  output  1  SHALL indicate the loader accepts a byte this cycle.
REQ-008 in_data  input  8  SHALL carry the program byte.
REQ-009 in_last  input  1  SHALL mark the final byte of the stream.
REQ-010 imem_we  output  1  SHALL be the instruction-memory write strobe.
REQ-011 imem_addr  output  ADDR_W  SHALL be the write address.
REQ-012 imem_wdata  output  8  SHALL be the write data.
REQ-013 cpu_status  input  2  SHALL be the processor status: 0 = running, 1 = halt, 2 = invalid instruction, 3 = error.
REQ-014 cpu_run  output  1  SHALL enable the processor, which holds its pc at 0 while cpu_run is 0.
REQ-015 load_err  output  1  SHALL flag a failed load.
REQ-016 final_status  output  2  SHALL hold the cpu_status value captured at halt.
REQ-017 byte_count  output  ADDR_W+1  SHALL count the bytes written in the current load.

Function
REQ-018 The FSM SHALL have the states IDLE, LOAD, RUN, HALTED and ERROR.
REQ-019 IDLE: on start, the FSM SHALL go to LOAD and clear byte_count, load_err and final_status.
REQ-020 in_ready SHALL be 1 only in LOAD; a byte SHALL be accepted when in_valid and in_ready are both 1.
REQ-021 Each accepted data byte SHALL produce exactly one registered write one cycle later:
- imem_we = 1;
- imem_addr = byte_count before the increment;
- imem_wdata = the accepted byte.
REQ-022 byte_count SHALL increment by 1 on every accepted data byte, saturating at MEM_BYTES.
REQ-023 An accepted in_last byte SHALL move the FSM to RUN on the following cycle, after its write is issued, and deassert in_ready.
REQ-024 Overflow: a byte accepted when byte_count equals MEM_BYTES SHALL NOT be written, and the FSM SHALL go to ERROR with load_err = 1.
REQ-025 RUN: cpu_run SHALL be 1. When cpu_status is nonzero, the FSM SHALL:
- capture cpu_status into final_status;
- set cpu_run = 0 on the next cycle;
- go to HALTED.
REQ-026 HALTED and ERROR: start SHALL restart LOAD exactly as from IDLE; otherwise the state SHALL hold.
REQ-027 start SHALL be ignored in LOAD and RUN.
REQ-028 An empty stream is impossible: the first in_last byte is always byte 0 or later.

Reset
REQ-029 Reset SHALL place the FSM in IDLE and drive the outputs as follows:
- in_ready = 0, imem_we = 0, imem_addr = 0, imem_wdata = 0;
- cpu_run = 0, load_err = 0, final_status = 0, byte_count = 0.
REQ-030 Reset asserted mid-LOAD or mid-RUN SHALL abort the operation immediately, drop any pending write, and require a fresh start.

Configuration
REQ-031 With PROG_LOADER_CHECKSUM_EN defined:
- the in_last byte SHALL be a checksum and SHALL NOT be written;
- the 8-bit modulo-256 sum of all data bytes SHALL be compared against it;
- on a match the FSM SHALL go to RUN, on a mismatch to ERROR with load_err = 1.
REQ-032 Without PROG_LOADER_CHECKSUM_EN, the in_last byte SHALL be written as ordinary data and no checksum logic SHALL exist.

Structure
REQ-033 A shared package SHALL hold:
- the FSM state enum;
- the status codes STAT_AOK = 0, STAT_HLT = 1, STAT_INS = 2, STAT_ERR = 3, shared with the processor top.
REQ-034 The block SHALL be a single module; the checksum accumulator SHALL remain inline logic and SHALL NOT be a sub-module.

Verification
REQ-035 Stream of 5 bytes 30 F2 0A 00 00 with in_last on byte 4 -> 5 writes at addresses 0..4; byte_count = 5; cpu_run = 1 two cycles after the last accept.
REQ-036 In RUN, cpu_status goes to 1 -> final_status = 1; cpu_run = 0 next cycle; state HALTED; a subsequent start pulse -> in_ready = 1.
REQ-037 MEM_BYTES = 16 with 17 bytes streamed -> 16 writes; the 17th byte is not written; load_err = 1; cpu_run stays 0.
REQ-038 in_valid toggled every other cycle -> no write occurs in a cycle without an accept; the address sequence has no gaps.
REQ-039 rst_n pulled low after 3 of 10 bytes -> all outputs return to their reset values asynchronously; the remaining bytes are ignored until start.
REQ-040 With PROG_LOADER_CHECKSUM_EN defined, data 01 02 03 with checksum 06 -> RUN; with checksum 07 -> ERROR and load_err = 1.
